uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Parametrised UART transmit engine. It combines the transmit control FSM, the data shift register, a one-entry holding buffer and a parity generator in a single block. It serialises DATA_WIDTH-bit words LSB-first onto txd, with runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. Bit timing comes from an external baud_tick pulse, one pulse per bit period, supplied by the baud generator.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9
CNT_W, $clog2(DATA_WIDTH), data bit counter width; derived, do not override

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
baud_tick  input  1  one-clk pulse per bit period
tx_start  input  1  write strobe; data accepted when tx_start && tx_ready
tx_data  input  DATA_WIDTH  word to transmit, sampled on accept
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none; latched at frame start
stop2  input  1  0 = one stop bit, 1 = two stop bits; latched at frame start
txd  output  1  serial line, registered, idles high
tx_ready  output  1  holding buffer empty (= !buf_valid)
tx_busy  output  1  registered; high while state != IDLE
tx_done  output  1  one-clk pulse at the end of each frame's last stop bit
tx_drop  output  1  one-clk pulse when tx_start arrives while tx_ready = 0; the word is discarded

Behaviour:
- Reset (rst_n = 0 at a clk edge): state = IDLE, txd = 1, tx_busy = 0, tx_done = 0, tx_drop = 0, buf_valid = 0 (tx_ready = 1), counters = 0.
- Reset has priority over all other inputs. Reset mid-frame aborts the frame and discards the buffer; txd returns to 1 on that same edge.
- Buffer accept: on an edge with tx_start && tx_ready, buf <= tx_data and buf_valid <= 1.
- tx_start while !tx_ready: buffer unchanged, tx_drop = 1 for one cycle.
- Accept and buffer-load never coincide: accept needs the buffer empty, load needs it full.
- FSM states are IDLE, START, DATA, PARITY, STOP. The state advances only on edges where baud_tick = 1, so each bit is held for exactly one tick period.
- txd is updated on the same edge as the state change.
- IDLE: txd = 1. On a tick with buf_valid:
  - state -> START, txd <= 0
  - shreg <= buf, buf_valid <= 0
  - latch parity_mode and stop2
  - par_bit <= ^buf for even parity, ~^buf for odd parity
  - Without buf_valid, stay in IDLE.
- START, on tick: state -> DATA, txd <= shreg[0], bit_cnt <= 0.
- DATA, on tick:
  - If bit_cnt != DATA_WIDTH-1: shift shreg right, txd <= next bit, bit_cnt++.
  - Else, with parity enabled: state -> PARITY, txd <= par_bit.
  - Else, with parity disabled: state -> STOP, txd <= 1, stop_cnt <= 0.
- PARITY, on tick: state -> STOP, txd <= 1, stop_cnt <= 0.
- STOP, on tick:
  - If latched stop2 && stop_cnt == 0: stay in STOP, stop_cnt <= 1.
  - Otherwise the frame ends: tx_done = 1 this cycle.
  - Frame end with buf_valid: back-to-back transmission, state -> START directly, txd <= 0, perform the IDLE load actions. No idle bit is inserted.
  - Frame end without buf_valid: state -> IDLE, txd stays 1.
- Frame length in ticks: 1 + DATA_WIDTH + (parity ? 1 : 0) + (stop2 ? 2 : 1).
- parity_mode and stop2 changes mid-frame have no effect on the current frame.
- tx_data is sampled only on accept, so the next word can be written any time after the buffer has loaded into shreg, including mid-frame.
- baud_tick has no effect on the buffer path. Accept works in any state.
- State encoding 3 bits. Unreachable encodings go to IDLE with txd = 1 on the next edge.

Test Plan:
1. Reset, then idle with ticks running -> txd = 1, tx_ready = 1, tx_busy = 0, tx_done never pulses.
2. DATA_WIDTH = 8, tick every 4 clk, parity 01, stop2 = 0, write 0xA5:
   - Required txd sequence: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1.
   - 11 ticks total; tx_done pulses once on the 11th tick; tx_busy then falls.
3. Same word 0xA5 with parity 10 and stop2 = 1 -> parity bit 1, two stop bits, 12 ticks.
4. Same word 0xA5 with parity 00 -> 10-tick frame, no parity bit.
5. Back-to-back, writes 0x3C then 0xC3:
   - Write 0x3C, then write 0xC3 during its DATA phase.
   - tx_ready drops on each accept and rises when the buffer loads.
   - Second START follows the last stop bit with no idle tick; two tx_done pulses.
   - A third write issued while the buffer is still full -> tx_drop pulses and that word never appears on txd.
6. rst_n low for one clk during DATA of 0xFF -> next edge: txd = 1, state IDLE, tx_ready = 1. No tx_done; a following write transmits normally.
   - Repeat test 2 at DATA_WIDTH = 5 and 9 to cover the counter boundaries.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter with one-entry holding buffer,
// LSB-first shift register, parity generator and 1/2 stop bits.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    output logic                  txd,
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_drop
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  buf_valid;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  par_bit;
    logic                  par_en_q;
    logic                  stop2_q;

    logic                  accept;
    logic                  last_bit;
    logic                  frame_end;
    logic                  load;
    logic                  par_en_in;
    logic                  par_in;

    assign tx_ready = !buf_valid;

    // Frame-level decisions derived from the current state and buffer.
    always_comb begin
        accept    = tx_start && !buf_valid;
        last_bit  = (bit_cnt == LAST);
        frame_end = (state == STOP) && !(stop2_q && !stop_cnt);
        load      = baud_tick && buf_valid &&
                    ((state == IDLE) || frame_end);
        par_en_in = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_in    = (parity_mode == 2'b10) ? ~^buf_q : ^buf_q;
    end

    // Holding buffer: filled on accept, emptied when a frame loads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_q     <= '0;
        end else if (load) begin
            buf_valid <= 1'b0;
        end else if (accept) begin
            buf_q     <= tx_data;
            buf_valid <= 1'b1;
        end
    end

    // Flag writes that arrive while the buffer still holds a word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_drop <= 1'b0;
        end else begin
            tx_drop <= tx_start && buf_valid;
        end
    end

    // Transmit FSM: one bit per baud tick, txd and flags registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (load) begin
                        state    <= START;
                        txd      <= 1'b0;
                        tx_busy  <= 1'b1;
                        shreg    <= buf_q;
                        par_en_q <= par_en_in;
                        stop2_q  <= stop2;
                        par_bit  <= par_in;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state   <= DATA;
                        txd     <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (!last_bit) begin
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (par_en_q) begin
                            state <= PARITY;
                            txd   <= par_bit;
                        end else begin
                            state    <= STOP;
                            txd      <= 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (!frame_end) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            tx_done <= 1'b1;
                            if (buf_valid) begin
                                state    <= START;
                                txd      <= 1'b0;
                                shreg    <= buf_q;
                                par_en_q <= par_en_in;
                                stop2_q  <= stop2;
                                par_bit  <= par_in;
                            end else begin
                                state   <= IDLE;
                                txd     <= 1'b1;
                                tx_busy <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized self-checking bench, three widths
// (5, 8, 9) driven in lockstep and decoded like a UART receiver.
`timescale 1ns/1ps
module tb_uart_tx_engine;

    localparam int TICK = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic       tx_start;
    logic       stop2;
    logic [1:0] parity_mode;
    logic [8:0] wdata;
    logic [2:0] txd, rdy, busy, done, drop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.DATA_WIDTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_start(tx_start), .tx_data(wdata[4:0]),
        .parity_mode(parity_mode), .stop2(stop2),
        .txd(txd[0]), .tx_ready(rdy[0]), .tx_busy(busy[0]),
        .tx_done(done[0]), .tx_drop(drop[0])
    );

    uart_tx_engine #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_start(tx_start), .tx_data(wdata[7:0]),
        .parity_mode(parity_mode), .stop2(stop2),
        .txd(txd[1]), .tx_ready(rdy[1]), .tx_busy(busy[1]),
        .tx_done(done[1]), .tx_drop(drop[1])
    );

    uart_tx_engine #(.DATA_WIDTH(9)) u9 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
        .tx_start(tx_start), .tx_data(wdata),
        .parity_mode(parity_mode), .stop2(stop2),
        .txd(txd[2]), .tx_ready(rdy[2]), .tx_busy(busy[2]),
        .tx_done(done[2]), .tx_drop(drop[2])
    );

    // free-running baud tick, one clk high every TICK clks
    int tcnt = 0;
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt == TICK - 1) ? 0 : tcnt + 1;
            baud_tick = (tcnt == 0);
        end
    end

    typedef struct packed {
        logic [2:0] t;
        logic [2:0] d;
    } samp_t;

    samp_t sq[$];
    logic  tick_q;
    int    done_cnt[3];

    always @(posedge clk) tick_q <= baud_tick;

    // one line sample per bit period, plus a raw tx_done pulse count
    always @(negedge clk) begin
        if (tick_q === 1'b1) sq.push_back({txd, done});
        for (int i = 0; i < 3; i++)
            if (done[i] === 1'b1) done_cnt[i] += 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [8:0] exp_w[$];
    logic [1:0] pm_e;
    bit         s2_e;
    bit         b2b_e;
    int         sb;
    int         db[3];

    function automatic logic st(input int k, input int i);
        return (k < sq.size()) ? sq[k].t[i] : 1'b1;
    endfunction

    function automatic logic sd(input int k, input int i);
        return (k < sq.size()) ? sq[k].d[i] : 1'b0;
    endfunction

    // receiver-style decode of the captured line against exp_w
    task automatic check_frames(input int i, input int dw);
        int pe = (pm_e == 2'b01 || pm_e == 2'b10) ? 1 : 0;
        int ns = s2_e ? 2 : 1;
        int tot = 1 + dw + pe + ns;
        int k = sb;
        int prev = -1;
        int stops;
        int zeros = 0;
        int bad_done = 0;
        bit endm[int];
        logic [8:0] got;
        logic [8:0] w;
        string nm = $sformatf("w%0d", dw);
        foreach (exp_w[f]) begin
            while (k < sq.size() && st(k, i) == 1'b1) k++;
            if (k >= sq.size()) begin
                chk({nm, " start"}, 32'd0, 32'd1);
                return;
            end
            if (b2b_e && prev >= 0)
                chk({nm, " gap"}, 32'(k), 32'(prev));
            w = exp_w[f] & 9'((1 << dw) - 1);
            got = '0;
            for (int j = 0; j < dw; j++) got[j] = st(k + 1 + j, i);
            chk({nm, " data"}, 32'(got), 32'(w));
            if (pe == 1)
                chk({nm, " parity"}, 32'(st(k + 1 + dw, i)),
                    32'(($countones(w) + (pm_e == 2'b10 ? 1 : 0)) % 2));
            stops = 0;
            for (int j = 0; j < ns; j++)
                stops += int'(st(k + 1 + dw + pe + j, i));
            chk({nm, " stop"}, 32'(stops), 32'(ns));
            prev = k + tot;
            endm[prev] = 1'b1;
            chk({nm, " done"}, 32'(sd(prev, i)), 32'd1);
            k = prev;
        end
        for (int j = (prev >= 0 ? prev : sb); j < sq.size(); j++)
            if (st(j, i) == 1'b0) zeros++;
        chk({nm, " extra"}, 32'(zeros), 32'd0);
        for (int j = sb; j < sq.size(); j++)
            if (sd(j, i) != endm.exists(j)) bad_done++;
        chk({nm, " done_pos"}, 32'(bad_done), 32'd0);
        chk({nm, " done_cnt"}, 32'(done_cnt[i] - db[i]),
            32'(exp_w.size()));
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (tick_q !== 1'b1) @(negedge clk);
        end
    endtask

    task automatic wait_ready();
        int b = 0;
        while (rdy != 3'b111 && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk("ready timeout", 32'(b < 2000), 32'd1);
    endtask

    task automatic wait_idle();
        int b = 0;
        @(negedge clk);
        while (!(busy == 3'b000 && rdy == 3'b111) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk("idle timeout", 32'(b < 2000), 32'd1);
    endtask

    task automatic send(input logic [8:0] w, input bit acc);
        tx_start = 1'b1;
        wdata    = w;
        @(negedge clk);
        tx_start = 1'b0;
        if (acc) begin
            chk("ready low", 32'(rdy), 32'd0);
            exp_w.push_back(w);
        end else begin
            chk("drop", 32'(drop), 32'h7);
            @(negedge clk);
            chk("drop pulse", 32'(drop), 32'd0);
        end
    endtask

    task automatic begin_test(input logic [1:0] pm, input bit s2,
                              input bit b2b);
        @(negedge clk);
        parity_mode = pm;
        stop2       = s2;
        pm_e        = pm;
        s2_e        = s2;
        b2b_e       = b2b;
        exp_w.delete();
        sb = sq.size();
        for (int i = 0; i < 3; i++) db[i] = done_cnt[i];
    endtask

    task automatic end_test();
        wait_idle();
        wait_ticks(3);
        check_frames(0, 5);
        check_frames(1, 8);
        check_frames(2, 9);
        chk("busy after", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pm;
        bit         s2;
        int         nw;
        rst_n       = 1'b0;
        tx_start    = 1'b0;
        wdata       = '0;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst txd", 32'(txd), 32'h7);
        chk("rst ready", 32'(rdy), 32'h7);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst drop", 32'(drop), 32'd0);
        rst_n = 1'b1;

        // idle with ticks running
        begin_test(2'b01, 1'b0, 1'b0);
        wait_ticks(20);
        end_test();

        // single frames of 0xA5 in three formats
        begin_test(2'b01, 1'b0, 1'b0);
        send(9'h0A5, 1'b1);
        end_test();
        begin_test(2'b10, 1'b1, 1'b0);
        send(9'h0A5, 1'b1);
        end_test();
        begin_test(2'b00, 1'b0, 1'b0);
        send(9'h0A5, 1'b1);
        end_test();

        // back-to-back with a dropped third write
        begin_test(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'b1);
        send(9'h03C, 1'b1);
        wait_ready();
        wait_ticks(2);
        send(9'h0C3, 1'b1);
        send(9'h099, 1'b0);
        end_test();

        // reset in the middle of a frame
        begin_test(2'b01, 1'b0, 1'b0);
        send(9'h1FF, 1'b1);
        wait_ready();
        wait_ticks(3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst txd", 32'(txd), 32'h7);
        chk("midrst ready", 32'(rdy), 32'h7);
        chk("midrst busy", 32'(busy), 32'd0);
        wait_ticks(2);
        chk("midrst nodone", 32'(done_cnt[1] - db[1]), 32'd0);
        exp_w.delete();
        sb = sq.size();
        send(9'h15A, 1'b1);
        end_test();

        // randomized words, formats and gaps
        for (int it = 0; it < 10; it++) begin
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 3);
            begin_test(pm, s2, 1'b0);
            for (int f = 0; f < nw; f++) begin
                wait_ready();
                repeat ($urandom_range(0, 6)) @(negedge clk);
                send(9'($urandom), 1'b1);
                if (nw == 1) begin
                    wait_ready();
                    parity_mode = ~pm;
                    stop2       = ~s2;
                end
            end
            end_test();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
